// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types and helpers for the fifo write-port arbiter
package fifo_wr_arb_pkg;

    localparam int MAX_REQ = 64;
    localparam int PICK_IDX_W = 6;

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Scan from the highest offset down so the nearest valid slot at or after ptr wins.
    function automatic pick_t rr_find_first(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
        pick_t r;
        int    idx;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    r.found = 1'b1;
                    r.idx   = idx[PICK_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational rotating-priority picker
module fifo_rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    pick_t pick;

    always_comb begin
        pick  = rr_find_first(MAX_REQ'(req), NUM_REQ, int'(ptr));
        any   = pick.found;
        idx   = pick.idx[IDX_W-1:0];
        grant = '0;
        if (pick.found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin arbiter sharing one fifo write port
// Optional multi-beat grants are enabled by defining FIFO_WR_ARB_BURST_EN.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 4,
    parameter int MAX_BURST   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [DEPTH_WIDTH:0]             fifo_cnt_i,
    output logic                             fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]            fifo_wr_data_o,
    output logic [idx_width(NUM_REQ)-1:0]    grant_id_o
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = DEPTH_WIDTH + 2;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_BURST < 1) begin : g_param_check
        $error("fifo_wr_arb: illegal parameter set");
    end

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    logic [CNT_W-1:0]      occ;
    logic                  room;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      ptr_next;
    logic [IDX_W-1:0]      pick_ptr;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    // The registered write in flight is counted so the fifo can never be overrun.
    assign occ  = CNT_W'(fifo_cnt_i) + CNT_W'(fifo_wr_en_o);
    assign room = occ < (CNT_W'(1) << DEPTH_WIDTH);

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid_i),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready_o = (room && !rst) ? pick_grant : '0;
    assign accept      = room && !rst && pick_any;
    assign sel_data    = req_data_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_next;
    logic [BURST_W-1:0] beat;
    logic               owner_idle;

    // An idle burst owner yields immediately so others can win in the same cycle.
    always_comb begin
        owner_idle     = (burst_cnt != '0) && !req_valid_i[ptr] && room;
        pick_ptr       = owner_idle ? inc_idx(ptr) : ptr;
        ptr_next       = ptr;
        burst_cnt_next = burst_cnt;
        beat           = '0;
        if (accept) begin
            beat = (pick_idx == ptr && burst_cnt != '0) ? burst_cnt + 1'b1 : BURST_W'(1);
            if (beat >= BURST_W'(MAX_BURST)) begin
                ptr_next       = inc_idx(pick_idx);
                burst_cnt_next = '0;
            end else begin
                ptr_next       = pick_idx;
                burst_cnt_next = beat;
            end
        end else if (owner_idle) begin
            ptr_next       = inc_idx(ptr);
            burst_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_next;
        end
    end
`else
    always_comb begin
        pick_ptr = ptr;
        ptr_next = accept ? inc_idx(pick_idx) : ptr;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en_o   <= 1'b0;
            fifo_wr_data_o <= '0;
            grant_id_o     <= '0;
        end else begin
            fifo_wr_en_o <= accept;
            if (accept) begin
                fifo_wr_data_o <= sel_data;
                grant_id_o     <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb
module tb_fifo_wr_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int DPW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     valid;
    logic [NR*DW-1:0]  data;
    logic [NR-1:0]     ready;
    logic [DPW:0]      cnt;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic [IW-1:0]     gid;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .DEPTH_WIDTH (DPW),
        .MAX_BURST   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (valid),
        .req_data_i     (data),
        .req_ready_o    (ready),
        .fifo_cnt_i     (cnt),
        .fifo_wr_en_o   (wr_en),
        .fifo_wr_data_o (wr_data),
        .grant_id_o     (gid)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [DW-1:0] base);
        for (int i = 0; i < NR; i++) data[i*DW +: DW] = base + DW'(i);
    endtask

    task automatic push(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id = IW'(id);
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain_check(input string name);
        valid = '0;
        tick();
        tick();
        tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst && wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_id", 64'(gid), 64'(e.id));
                check("wr_data", 64'(wr_data), 64'(e.d));
            end
        end
    end

    // T6 state
    int            occ;
    int            m_ptr;
    bit            m_inflight;
    bit            m_acc;
    int            m_idx;
    logic [NR-1:0] exp_rdy;
    int            seq;

    initial begin
        rst   = 1'b0;
        valid = '0;
        data  = '0;
        cnt   = '0;
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_gid", 64'(gid), 64'd0);
        valid = 4'b1111;
        #1 check("rst_ready", 64'(ready), 64'd0);
        rst = 1'b0;

        // T1: reset during an in-flight write
        set_data(32'h1111_0000);
        tick();
        check("t1_inflight", 64'(wr_en), 64'd1);
        rst = 1'b1;
        #1;
        check("t1_wr_en_async", 64'(wr_en), 64'd0);
        check("t1_ready_in_rst", 64'(ready), 64'd0);
        tick();
        rst = 1'b0;
        #1 check("t1_ptr0", 64'(ready), 64'b0001);
        valid = '0;
        tick();
        mon_en = 1'b1;

        // T3: full boundary with the in-flight write counted
        set_data(32'h3333_0000);
        valid = 4'b0001;
        cnt = 5'd14;
        push(0, 32'h3333_0000);
        tick();
        cnt = 5'd15;
        #1 check("t3_full_inflight", 64'(ready), 64'd0);
        tick();
        check("t3_no_write", 64'(wr_en), 64'd0);
        cnt = 5'd14;
        push(0, 32'h3333_0000);
        #1 check("t3_one_accept", 64'(ready), 64'b0001);
        tick();
        cnt = 5'd15;
        #1 check("t3_full_again", 64'(ready), 64'd0);
        tick();
        check("t3_single_write", 64'(wr_en), 64'd0);
        cnt = '0;
        drain_check("t3_drained");
        do_reset();

`ifdef FIFO_WR_ARB_BURST_EN
        // T5: bursts of four, early yield when the owner drops valid
        set_data(32'h5555_0000);
        valid = 4'b1111;
        for (int i = 0; i < 4; i++) push(0, 32'h5555_0000);
        for (int i = 0; i < 2; i++) push(1, 32'h5555_0001);
        #1 check("t5_first", 64'(ready), 64'b0001);
        for (int i = 0; i < 6; i++) tick();
        valid = 4'b1101;
        for (int i = 0; i < 4; i++) push(2, 32'h5555_0002);
        push(3, 32'h5555_0003);
        #1 check("t5_switch_same_cycle", 64'(ready), 64'b0100);
        for (int i = 0; i < 5; i++) tick();
        drain_check("t5_drained");
`else
        // T2: fairness with all requesters valid
        set_data(32'h2222_0000);
        valid = 4'b1111;
        for (int i = 0; i < 8; i++) push(i % NR, 32'h2222_0000 + DW'(i % NR));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_wr_every_cycle", 64'(wr_en), 64'd1);
        end
        drain_check("t2_drained");
        do_reset();

        // T4: sparse requesters with wrap from pointer 2
        set_data(32'hA5A5_0000);
        valid = 4'b0010;
        push(1, 32'hA5A5_0001);
        tick();
        valid = 4'b1010;
        push(3, 32'hA5A5_0003);
        push(1, 32'hA5A5_0001);
        push(3, 32'hA5A5_0003);
        #1 check("t4_first_pick", 64'(ready), 64'b1000);
        tick();
        tick();
        tick();
        drain_check("t4_drained");
        do_reset();

        // T6: random traffic against a reference model and fifo occupancy model
        occ = 0;
        m_ptr = 0;
        m_inflight = 1'b0;
        seq = 0;
        valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!valid[i] && $urandom_range(0, 2) != 0) begin
                    valid[i] = 1'b1;
                    data[i*DW +: DW] = {8'(i), 24'(seq)};
                    seq++;
                end
            end
            cnt = (DPW+1)'(occ);
            m_acc = 1'b0;
            m_idx = 0;
            exp_rdy = '0;
            if (occ + int'(m_inflight) < 16) begin
                for (int k = NR - 1; k >= 0; k--) begin
                    if (valid[(m_ptr + k) % NR]) begin
                        m_acc = 1'b1;
                        m_idx = (m_ptr + k) % NR;
                    end
                end
            end
            if (m_acc) exp_rdy[m_idx] = 1'b1;
            #1 check("t6_ready", 64'(ready), 64'(exp_rdy));
            if (m_acc) begin
                push(m_idx, data[m_idx*DW +: DW]);
                m_ptr = (m_idx + 1) % NR;
            end
            occ = occ + int'(wr_en);
            tick();
            if (m_acc) begin
                valid[m_idx] = 1'b0;
                if ($urandom_range(0, 1) != 0) begin
                    valid[m_idx] = 1'b1;
                    data[m_idx*DW +: DW] = {8'(m_idx), 24'(seq)};
                    seq++;
                end
            end
            m_inflight = m_acc;
            if (occ > 0 && $urandom_range(0, 2) == 0) occ = occ - 1;
            if (occ > 16) check("t6_fifo_overflow", 64'(occ), 64'd16);
        end
        cnt = '0;
        drain_check("t6_drained");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
